alu_wb_buffer: RTL and testbench

ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

---
 rtl/alu_wb_buffer.sv | 89 ++++++++
 tb/tb_alu_wb_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: small FIFO that decouples ALU results from the writeback port.
// Each entry holds the scoreboard ID, the 64-bit result and the branch outcome.
// Occupancy is tracked by a dedicated counter, so full and empty are never
// inferred from pointer equality. Both pointers wrap modulo DEPTH.
module alu_wb_buffer #(
    parameter int DEPTH         = 4,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       alu_valid_i,
    output logic                       alu_ready_o,
    input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
    input  logic [63:0]                result_i,
    input  logic                       branch_res_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [63:0]                wb_result_o,
    output logic                       wb_branch_res_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [63:0]              result;
        logic                     branch_res;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    entry_t             head;

    // Handshakes depend only on registered occupancy; flush cancels both sides.
    assign alu_ready_o = (count != FULL_CNT);
    assign wb_valid_o  = (count != '0);
    assign push        = alu_valid_i && alu_ready_o && !flush_i;
    assign pop         = wb_valid_o && wb_ready_i && !flush_i;
    assign count_o     = count;

    // Pointer and occupancy update; flush and reset both return to empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observable while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{trans_id: trans_id_i, result: result_i, branch_res: branch_res_i};
        end
    end

    // Head read from storage, forced to zero whenever the buffer is empty
    // (which includes the whole time reset is asserted).
    always_comb begin
        head = '0;
        if (wb_valid_o) head = mem[rd_ptr];
    end

    assign wb_trans_id_o   = head.trans_id;
    assign wb_result_o     = head.result;
    assign wb_branch_res_o = head.branch_res;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer at default parameters (DEPTH=4, 3-bit IDs).
module tb_alu_wb_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [2:0]  trans_id_i;
    logic [63:0] result_i;
    logic        branch_res_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [2:0]  wb_trans_id_o;
    logic [63:0] wb_result_o;
    logic        wb_branch_res_o;
    logic [2:0]  count_o;

    int vectors     = 0;
    int miscompares = 0;

    alu_wb_buffer #(.DEPTH(4), .TRANS_ID_BITS(3)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .alu_valid_i    (alu_valid_i),
        .alu_ready_o    (alu_ready_o),
        .trans_id_i     (trans_id_i),
        .result_i       (result_i),
        .branch_res_i   (branch_res_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_trans_id_o  (wb_trans_id_o),
        .wb_result_o    (wb_result_o),
        .wb_branch_res_o(wb_branch_res_o),
        .count_o        (count_o)
    );

    always #5 clk_i = ~clk_i;

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; alu_valid_i = 1'b0; wb_ready_i = 1'b0;
        trans_id_i = '0; result_i = '0; branch_res_i = 1'b0;
        #2;
        vectors++;
        if ({wb_valid_o, alu_ready_o, count_o} !== {1'b0, 1'b1, 3'd0}) begin
            $display("FAIL reset_flags: got v=%b r=%b cnt=%0d, want v=0 r=1 cnt=0", wb_valid_o, alu_ready_o, count_o);
            miscompares++;
        end
        vectors++;
        if ({wb_trans_id_o, wb_result_o, wb_branch_res_o} !== 68'd0) begin
            $display("FAIL reset_data: got id=%0d res=%h br=%b, want all 0", wb_trans_id_o, wb_result_o, wb_branch_res_o);
            miscompares++;
        end
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_single_push();
        wb_ready_i = 1'b1; alu_valid_i = 1'b1;
        trans_id_i = 3'd2; result_i = 64'hDEAD_BEEF; branch_res_i = 1'b1;
        step();
        alu_valid_i = 1'b0;
        vectors++;
        if ({wb_valid_o, count_o, wb_trans_id_o, wb_result_o, wb_branch_res_o} !==
            {1'b1, 3'd1, 3'd2, 64'hDEAD_BEEF, 1'b1}) begin
            $display("FAIL single_out: got v=%b cnt=%0d id=%0d res=%h br=%b, want v=1 cnt=1 id=2 res=deadbeef br=1",
                     wb_valid_o, count_o, wb_trans_id_o, wb_result_o, wb_branch_res_o);
            miscompares++;
        end
        step();
        vectors++;
        if ({wb_valid_o, count_o} !== {1'b0, 3'd0}) begin
            $display("FAIL single_drain: got v=%b cnt=%0d, want v=0 cnt=0", wb_valid_o, count_o);
            miscompares++;
        end
        // pop request on an empty buffer must not underflow
        step();
        vectors++;
        if ({wb_valid_o, count_o, alu_ready_o} !== {1'b0, 3'd0, 1'b1}) begin
            $display("FAIL empty_pop: got v=%b cnt=%0d r=%b, want v=0 cnt=0 r=1", wb_valid_o, count_o, alu_ready_o);
            miscompares++;
        end
    endtask

    task automatic test_fill_stall();
        wb_ready_i = 1'b0; branch_res_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu_valid_i = 1'b1; trans_id_i = 3'(i); result_i = 64'(i) + 64'h100;
            step();
        end
        vectors++;
        if ({count_o, alu_ready_o} !== {3'd4, 1'b0}) begin
            $display("FAIL fill_full: got cnt=%0d r=%b, want cnt=4 r=0", count_o, alu_ready_o);
            miscompares++;
        end
        trans_id_i = 3'd4; result_i = 64'h104;
        step();
        alu_valid_i = 1'b0;
        vectors++;
        if ({count_o, wb_trans_id_o} !== {3'd4, 3'd0}) begin
            $display("FAIL fill_ignore: got cnt=%0d head=%0d, want cnt=4 head=0", count_o, wb_trans_id_o);
            miscompares++;
        end
        wb_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({wb_valid_o, wb_trans_id_o, wb_result_o} !== {1'b1, 3'(i), 64'(i) + 64'h100}) begin
                $display("FAIL fill_order[%0d]: got v=%b id=%0d res=%h, want v=1 id=%0d res=%h",
                         i, wb_valid_o, wb_trans_id_o, wb_result_o, i, 64'(i) + 64'h100);
                miscompares++;
            end
            step();
        end
        vectors++;
        if ({wb_valid_o, count_o} !== {1'b0, 3'd0}) begin
            $display("FAIL fill_drained: got v=%b cnt=%0d, want v=0 cnt=0", wb_valid_o, count_o);
            miscompares++;
        end
    endtask

    task automatic test_full_pop();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu_valid_i = 1'b1; trans_id_i = 3'(i); result_i = 64'(i);
            step();
        end
        wb_ready_i = 1'b1; alu_valid_i = 1'b1; trans_id_i = 3'd5; result_i = 64'h5;
        step();
        alu_valid_i = 1'b0; wb_ready_i = 1'b0;
        vectors++;
        if ({count_o, alu_ready_o, wb_trans_id_o} !== {3'd3, 1'b1, 3'd1}) begin
            $display("FAIL full_pop: got cnt=%0d r=%b head=%0d, want cnt=3 r=1 head=1", count_o, alu_ready_o, wb_trans_id_o);
            miscompares++;
        end
        wb_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            vectors++;
            if ({wb_valid_o, wb_trans_id_o} !== {1'b1, 3'(i)}) begin
                $display("FAIL full_order[%0d]: got v=%b id=%0d, want v=1 id=%0d", i, wb_valid_o, wb_trans_id_o, i);
                miscompares++;
            end
            step();
        end
        vectors++;
        if ({wb_valid_o, count_o} !== {1'b0, 3'd0}) begin
            $display("FAIL full_drained: got v=%b cnt=%0d (ID 5 must never be stored), want v=0 cnt=0", wb_valid_o, count_o);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            alu_valid_i = 1'b1; trans_id_i = 3'(i); result_i = 64'(i) * 64'd3;
            step();
        end
        wb_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            alu_valid_i = 1'b1; trans_id_i = 3'(k + 2); result_i = 64'(k + 2) * 64'd3;
            vectors++;
            if ({count_o, wb_trans_id_o, wb_result_o} !== {3'd2, 3'(k), 64'(k) * 64'd3}) begin
                $display("FAIL wrap[%0d]: got cnt=%0d id=%0d res=%h, want cnt=2 id=%0d res=%h",
                         k, count_o, wb_trans_id_o, wb_result_o, k % 8, 64'(k) * 64'd3);
                miscompares++;
            end
            step();
        end
        alu_valid_i = 1'b0;
        for (int k = 10; k < 12; k++) begin
            vectors++;
            if ({wb_valid_o, wb_trans_id_o} !== {1'b1, 3'(k)}) begin
                $display("FAIL wrap_tail[%0d]: got v=%b id=%0d, want v=1 id=%0d", k, wb_valid_o, wb_trans_id_o, k % 8);
                miscompares++;
            end
            step();
        end
        vectors++;
        if (count_o !== 3'd0) begin
            $display("FAIL wrap_drained: got cnt=%0d, want 0", count_o);
            miscompares++;
        end
    endtask

    task automatic test_flush();
        wb_ready_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            alu_valid_i = 1'b1; trans_id_i = 3'(i); result_i = 64'(i);
            step();
        end
        flush_i = 1'b1; alu_valid_i = 1'b1; trans_id_i = 3'd7; result_i = 64'h7; wb_ready_i = 1'b1;
        step();
        flush_i = 1'b0; alu_valid_i = 1'b0; wb_ready_i = 1'b0;
        vectors++;
        if ({count_o, wb_valid_o, alu_ready_o} !== {3'd0, 1'b0, 1'b1}) begin
            $display("FAIL flush_empty: got cnt=%0d v=%b r=%b, want cnt=0 v=0 r=1", count_o, wb_valid_o, alu_ready_o);
            miscompares++;
        end
        alu_valid_i = 1'b1; trans_id_i = 3'd4; result_i = 64'h44;
        step();
        alu_valid_i = 1'b0;
        vectors++;
        if ({count_o, wb_trans_id_o, wb_result_o} !== {3'd1, 3'd4, 64'h44}) begin
            $display("FAIL flush_next: got cnt=%0d id=%0d res=%h, want cnt=1 id=4 res=44", count_o, wb_trans_id_o, wb_result_o);
            miscompares++;
        end
        wb_ready_i = 1'b1;
        step();
        wb_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        wb_ready_i = 1'b0;
        for (int i = 1; i < 3; i++) begin
            alu_valid_i = 1'b1; trans_id_i = 3'(i); result_i = 64'(i);
            step();
        end
        alu_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        vectors++;
        if ({wb_valid_o, count_o, alu_ready_o, wb_trans_id_o, wb_result_o} !== {1'b0, 3'd0, 1'b1, 3'd0, 64'd0}) begin
            $display("FAIL async_reset: got v=%b cnt=%0d r=%b id=%0d res=%h, want v=0 cnt=0 r=1 id=0 res=0",
                     wb_valid_o, count_o, alu_ready_o, wb_trans_id_o, wb_result_o);
            miscompares++;
        end
        step();
        rst_ni = 1'b1;
        alu_valid_i = 1'b1; trans_id_i = 3'd6; result_i = 64'h66;
        step();
        alu_valid_i = 1'b0;
        vectors++;
        if ({wb_valid_o, count_o, wb_trans_id_o, wb_result_o} !== {1'b1, 3'd1, 3'd6, 64'h66}) begin
            $display("FAIL post_reset: got v=%b cnt=%0d id=%0d res=%h, want v=1 cnt=1 id=6 res=66",
                     wb_valid_o, count_o, wb_trans_id_o, wb_result_o);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_stall();
        test_full_pop();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
